// File: rtl/chan_scan_pkg.sv
// Shared definitions for chan_scan_mux: FSM state encoding and the clog2 helper.
// No logic, no latency, no flow control.
package chan_scan_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational N_CH x WIDTH selector; an index outside 0..N_CH-1 yields zero.
// Zero latency, no flow control.
module mux_n #(
   parameter int N_CH  = 8,
   parameter int WIDTH = 1,
   parameter int SELW  = 3
) (
   input  logic [N_CH*WIDTH-1:0] d,
   input  logic [SELW-1:0]       sel,
   output logic [WIDTH-1:0]      y
);

   always_comb begin
      y = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (int'(sel) == k) y = d[k*WIDTH +: WIDTH];
      end
   end

endmodule

// File: rtl/chan_scan_mux.sv
// Registered N:1 channel selector with manual select and DWELL-paced auto-scan.
// Manual path is 1 cycle sel/d -> y; scan ignores mode/sel/start until it returns to IDLE.
module chan_scan_mux
   import chan_scan_pkg::*;
#(
   parameter int N_CH  = 8,
   parameter int WIDTH = 1,
   parameter int DWELL = 4,
   localparam int SELW = clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mode,
   input  logic [SELW-1:0]       sel,
   input  logic                  start,
   input  logic [N_CH*WIDTH-1:0] d,
   output logic [WIDTH-1:0]      y,
   output logic [SELW-1:0]       ch,
   output logic                  y_valid,
   output logic                  busy,
   output logic                  done
);

   localparam int CNTW = (DWELL > 1) ? clog2(DWELL) : 1;
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
   localparam logic [SELW-1:0] PTR_LAST = SELW'(N_CH - 1);

   logic [1:0]       state;
   logic [SELW-1:0]  ptr;
   logic [CNTW-1:0]  cnt;
   logic [SELW-1:0]  mux_sel;
   logic [WIDTH-1:0] mux_dat;
   logic             sel_in_range;

   // One selector serves both paths: sel while idle, the scan pointer otherwise.
   assign mux_sel      = (state == ST_IDLE) ? sel : ptr;
   assign sel_in_range = int'(sel) < N_CH;

   mux_n #(
      .N_CH  (N_CH),
      .WIDTH (WIDTH),
      .SELW  (SELW)
   ) u_mux (
      .d   (d),
      .sel (mux_sel),
      .y   (mux_dat)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         ptr     <= '0;
         cnt     <= '0;
         y       <= '0;
         ch      <= '0;
         y_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!mode) begin
                  y       <= mux_dat;
                  ch      <= sel;
                  y_valid <= sel_in_range;
               end else begin
                  y_valid <= 1'b0;
                  if (start) begin
                     state <= ST_SCAN;
                     ptr   <= '0;
                     cnt   <= '0;
                  end
               end
            end
            ST_SCAN: begin
               if (cnt == CNT_LAST) begin
                  y       <= mux_dat;
                  ch      <= ptr;
                  y_valid <= 1'b1;
                  cnt     <= '0;
                  if (ptr == PTR_LAST) begin
                     state <= ST_DONE;
                     ptr   <= '0;
                  end else begin
                     ptr <= ptr + 1'b1;
                  end
               end else begin
                  cnt     <= cnt + 1'b1;
                  y_valid <= 1'b0;
               end
            end
            ST_DONE: begin
               state   <= ST_IDLE;
               y_valid <= 1'b0;
            end
            default: begin
               state   <= ST_IDLE;
               y_valid <= 1'b0;
            end
         endcase
      end
   end

   assign busy = (state == ST_SCAN);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_chan_scan_mux.sv
// Bench for chan_scan_mux: three configurations (8x1 D4, 4x4 D2, 5x4 D1) on one clock/reset.
module tb_chan_scan_mux;

   logic       clk = 1'b0;
   logic       reset;
   logic       mode_i  [3];
   logic       start_i [3];
   logic [2:0] sel_i   [3];
   logic [3:0] chv     [3][8];

   logic [7:0]  d_a;
   logic [15:0] d_b;
   logic [19:0] d_c;

   logic       y_a;
   logic [3:0] y_b, y_c;
   logic [2:0] ch_a, ch_c;
   logic [1:0] ch_b;
   logic       v_a, v_b, v_c, b_a, b_b, b_c, dn_a, dn_b, dn_c;

   logic [3:0] oy  [3];
   logic [2:0] och [3];
   logic       ov  [3];
   logic       ob  [3];
   logic       od  [3];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   always_comb begin
      d_a = '0;
      d_b = '0;
      d_c = '0;
      for (int k = 0; k < 8; k++) d_a[k] = chv[0][k][0];
      for (int k = 0; k < 4; k++) d_b[k*4 +: 4] = chv[1][k];
      for (int k = 0; k < 5; k++) d_c[k*4 +: 4] = chv[2][k];
   end

   assign oy[0]  = {3'b000, y_a};
   assign oy[1]  = y_b;
   assign oy[2]  = y_c;
   assign och[0] = ch_a;
   assign och[1] = {1'b0, ch_b};
   assign och[2] = ch_c;
   assign ov[0]  = v_a;
   assign ov[1]  = v_b;
   assign ov[2]  = v_c;
   assign ob[0]  = b_a;
   assign ob[1]  = b_b;
   assign ob[2]  = b_c;
   assign od[0]  = dn_a;
   assign od[1]  = dn_b;
   assign od[2]  = dn_c;

   chan_scan_mux #(.N_CH(8), .WIDTH(1), .DWELL(4)) u_a (
      .clk(clk), .reset(reset), .mode(mode_i[0]), .sel(sel_i[0]), .start(start_i[0]),
      .d(d_a), .y(y_a), .ch(ch_a), .y_valid(v_a), .busy(b_a), .done(dn_a));

   chan_scan_mux #(.N_CH(4), .WIDTH(4), .DWELL(2)) u_b (
      .clk(clk), .reset(reset), .mode(mode_i[1]), .sel(sel_i[1][1:0]), .start(start_i[1]),
      .d(d_b), .y(y_b), .ch(ch_b), .y_valid(v_b), .busy(b_b), .done(dn_b));

   chan_scan_mux #(.N_CH(5), .WIDTH(4), .DWELL(1)) u_c (
      .clk(clk), .reset(reset), .mode(mode_i[2]), .sel(sel_i[2]), .start(start_i[2]),
      .d(d_c), .y(y_c), .ch(ch_c), .y_valid(v_c), .busy(b_c), .done(dn_c));

   typedef struct {
      logic [2:0] sel;
      logic [7:0] d;
      logic       exp_y;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input int i, input string tag);
      check({tag, "_y"},    32'(oy[i]),  0);
      check({tag, "_ch"},   32'(och[i]), 0);
      check({tag, "_vld"},  32'(ov[i]),  0);
      check({tag, "_busy"}, 32'(ob[i]),  0);
      check({tag, "_done"}, 32'(od[i]),  0);
   endtask

   // Expected scan trace from the edge count t since the start edge:
   // busy for t < n*dw, done at t == n*dw, a sample of channel t/dw-1 at every multiple of dw.
   task automatic run_scan(input int i, input int n, input int dw, input bit disturb);
      int total;
      total = n * dw;
      mode_i[i]  = 1'b1;
      start_i[i] = 1'b1;
      step();
      start_i[i] = 1'b0;
      check("scan_t0_busy", 32'(ob[i]), 1);
      check("scan_t0_vld",  32'(ov[i]), 0);
      check("scan_t0_done", 32'(od[i]), 0);
      for (int t = 1; t <= total + 1; t++) begin
         if (disturb) begin
            start_i[i] = 1'($urandom);
            mode_i[i]  = 1'($urandom);
            sel_i[i]   = 3'($urandom);
         end
         step();
         check("scan_busy", 32'(ob[i]), (t < total) ? 1 : 0);
         check("scan_done", 32'(od[i]), (t == total) ? 1 : 0);
         check("scan_vld",  32'(ov[i]), (t <= total && t % dw == 0) ? 1 : 0);
         if (t <= total && t % dw == 0) begin
            check("scan_y",  32'(oy[i]),  32'(chv[i][t/dw-1]));
            check("scan_ch", 32'(och[i]), t/dw - 1);
         end
      end
      mode_i[i]  = 1'b1;
      start_i[i] = 1'b0;
      check("scan_end_y",  32'(oy[i]),  32'(chv[i][n-1]));
      check("scan_end_ch", 32'(och[i]), n - 1);
      step();
      check("idle_hold_y",    32'(oy[i]),  32'(chv[i][n-1]));
      check("idle_hold_vld",  32'(ov[i]),  0);
      check("idle_hold_busy", 32'(ob[i]),  0);
   endtask

   initial begin
      vec_t tbl[10];
      logic [2:0] s;
      logic [3:0] expv;

      tbl[0] = '{3'd0, 8'h96, 1'b0};
      tbl[1] = '{3'd1, 8'h96, 1'b1};
      tbl[2] = '{3'd2, 8'h96, 1'b1};
      tbl[3] = '{3'd3, 8'h96, 1'b0};
      tbl[4] = '{3'd4, 8'h96, 1'b1};
      tbl[5] = '{3'd5, 8'h96, 1'b0};
      tbl[6] = '{3'd6, 8'h96, 1'b0};
      tbl[7] = '{3'd7, 8'h96, 1'b1};
      tbl[8] = '{3'd3, 8'hFF, 1'b1};
      tbl[9] = '{3'd7, 8'h7F, 1'b0};

      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mode_i[i] = 1'b0;
         start_i[i] = 1'b0;
         sel_i[i] = 3'd0;
         for (int k = 0; k < 8; k++) chv[i][k] = 4'h0;
      end
      repeat (2) step();
      for (int i = 0; i < 3; i++) check_zero(i, "reset");
      reset = 1'b0;

      // Manual mode, 8x1: table of select/data vectors.
      for (int r = 0; r < 10; r++) begin
         sel_i[0] = tbl[r].sel;
         for (int k = 0; k < 8; k++) chv[0][k] = {3'b000, tbl[r].d[k]};
         step();
         check("man_a_y",   32'(oy[0]),  32'(tbl[r].exp_y));
         check("man_a_ch",  32'(och[0]), 32'(tbl[r].sel));
         check("man_a_vld", 32'(ov[0]),  1);
      end

      for (int r = 0; r < 16; r++) begin
         s = 3'($urandom);
         sel_i[0] = s;
         for (int k = 0; k < 8; k++) chv[0][k] = 4'($urandom_range(0, 1));
         expv = chv[0][s];
         step();
         check("rnd_a_y",  32'(oy[0]),  32'(expv));
         check("rnd_a_ch", 32'(och[0]), 32'(s));
      end

      // Scan 4x4, DWELL=2, channels A,B,C,D.
      chv[1][0] = 4'hA;
      chv[1][1] = 4'hB;
      chv[1][2] = 4'hC;
      chv[1][3] = 4'hD;
      run_scan(1, 4, 2, 1'b0);
      run_scan(1, 4, 2, 1'b1);

      mode_i[1] = 1'b0;
      sel_i[1]  = 3'd2;
      step();
      check("resume_y",   32'(oy[1]),  32'hC);
      check("resume_ch",  32'(och[1]), 2);
      check("resume_vld", 32'(ov[1]),  1);

      // Reset during a scan: outputs clear without a clock, and no done follows.
      mode_i[1]  = 1'b1;
      start_i[1] = 1'b1;
      step();
      start_i[1] = 1'b0;
      step();
      step();
      check("abort_pre_y", 32'(oy[1]), 32'hA);
      step();
      check("abort_pre_busy", 32'(ob[1]), 1);
      #2;
      reset = 1'b1;
      #1;
      check_zero(1, "abort_async");
      step();
      reset = 1'b0;
      for (int t = 0; t < 10; t++) begin
         step();
         check("abort_no_done", 32'(od[1]), 0);
         check("abort_no_busy", 32'(ob[1]), 0);
      end

      // 5 channels, WIDTH=4: out-of-range selects give zero and no valid.
      for (int k = 0; k < 8; k++) chv[2][k] = 4'hF;
      mode_i[2] = 1'b0;
      for (int s5 = 5; s5 < 8; s5++) begin
         sel_i[2] = 3'(s5);
         step();
         check("oor_y",   32'(oy[2]),  0);
         check("oor_vld", 32'(ov[2]),  0);
         check("oor_ch",  32'(och[2]), s5);
      end

      for (int r = 0; r < 20; r++) begin
         s = 3'($urandom);
         sel_i[2] = s;
         for (int k = 0; k < 8; k++) chv[2][k] = 4'($urandom);
         expv = (s < 3'd5) ? chv[2][s] : 4'h0;
         step();
         check("rnd_c_y",   32'(oy[2]), 32'(expv));
         check("rnd_c_vld", 32'(ov[2]), (s < 3'd5) ? 1 : 0);
      end

      for (int k = 0; k < 8; k++) chv[2][k] = 4'($urandom);
      run_scan(2, 5, 1, 1'b0);

      mode_i[0] = 1'b0;
      for (int k = 0; k < 8; k++) chv[0][k] = 4'($urandom_range(0, 1));
      run_scan(0, 8, 4, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
